udp_tx_arbiter: RTL and testbench

- Round-robin scheduler that shares the single UDP transmit engine inside the Ethernet/UDP stack between N_REQ local requesters.
- Arbitrates between requesters and latches the winner's payload length.
- Issues a one-cycle start to the engine, muxes the winner's byte stream to the engine, and waits for frame completion.
- Enforces an inter-frame gap and a completion timeout before re-arbitrating.
- Sits between application sources (test pattern generator, loopback of received UDP data, status reporter) and the UDP/IP/MAC transmit path on the GMII side.

---
 rtl/udp_tx_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
// rtl/udp_tx_arbiter.sv - round-robin scheduler sharing one UDP transmit engine between N_REQ requesters
module udp_tx_arbiter #(
  parameter int          N_REQ          = 4,
  parameter logic [15:0] MAX_LEN        = 16'd1472,
  parameter int          IFG_CYCLES     = 12,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000
) (
  input  logic                 rgmii_clk,
  input  logic                 rstn,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  req_len,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_data_valid,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     req_done,
  output logic [N_REQ-1:0]     req_err,
  input  logic                 udp_tx_ready,
  output logic                 udp_tx_start,
  output logic [15:0]          udp_tx_length,
  output logic [7:0]           udp_tx_data,
  output logic                 udp_tx_data_valid,
  input  logic                 udp_tx_done,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam logic [2:0]  S_IDLE  = 3'd0;
  localparam logic [2:0]  S_ARB   = 3'd1;
  localparam logic [2:0]  S_START = 3'd2;
  localparam logic [2:0]  S_BUSY  = 3'd3;
  localparam logic [2:0]  S_GAP   = 3'd4;
  localparam logic [19:0] IFG_LAST = 20'(IFG_CYCLES - 1);
  localparam logic [19:0] TMO_LAST = TIMEOUT_CYCLES - 20'd1;

  logic [2:0]       state_q, state_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [2:0]       idx_q, idx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic             tmo_q, tmo_d;
  logic [15:0]      len_q, len_d;
  logic [19:0]      timer_q, timer_d;

  // Requester buses padded to 8 lanes so a 3-bit index never selects out of range.
  logic [7:0]  req_pad;
  logic [7:0]  vld_pad;
  logic [15:0] len_arr [8];
  logic [7:0]  dat_arr [8];

  for (genvar g = 0; g < 8; g++) begin : g_pad
    if (g < N_REQ) begin : g_on
      assign req_pad[g] = req[g];
      assign vld_pad[g] = req_data_valid[g];
      assign len_arr[g] = req_len[16*g +: 16];
      assign dat_arr[g] = req_data[8*g +: 8];
    end else begin : g_off
      assign req_pad[g] = 1'b0;
      assign vld_pad[g] = 1'b0;
      assign len_arr[g] = 16'd0;
      assign dat_arr[g] = 8'd0;
    end
  end

  logic [2:0]  win_idx;
  logic        win_found;
  logic [3:0]  cand;
  logic [7:0]  win_oh;
  logic [7:0]  idx_oh;
  logic [15:0] win_len;

  always_comb begin
    win_idx   = 3'd0;
    win_found = 1'b0;
    cand      = 4'd0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + 4'(k);
      if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
      if (!win_found && req_pad[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  assign win_oh  = 8'd1 << win_idx;
  assign idx_oh  = 8'd1 << idx_q;
  assign win_len = len_arr[win_idx];

  function automatic logic [2:0] ptr_after(input logic [2:0] i);
    return (i == 3'(N_REQ - 1)) ? 3'd0 : i + 3'd1;
  endfunction

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = '0;
    tmo_d    = 1'b0;
    len_d    = len_q;
    timer_d  = timer_q;
    case (state_q)
      S_IDLE: if (udp_tx_ready && (|req)) state_d = S_ARB;
      S_ARB: begin
        timer_d = 20'd0;
        if (!win_found) begin
          state_d = S_IDLE;
        end else begin
          idx_d = win_idx;
          if (win_len == 16'd0 || win_len > MAX_LEN) begin
            err_d    = win_oh[N_REQ-1:0];
            rr_ptr_d = ptr_after(win_idx);
            state_d  = S_IDLE;
          end else begin
            gnt_d   = win_oh[N_REQ-1:0];
            len_d   = win_len;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        timer_d = timer_q + 20'd1;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        timer_d = timer_q + 20'd1;
        // A done arriving on the timeout cycle counts as a normal completion.
        if (udp_tx_done || timer_q == TMO_LAST) begin
          done_d   = idx_oh[N_REQ-1:0];
          tmo_d    = !udp_tx_done;
          gnt_d    = '0;
          len_d    = 16'd0;
          rr_ptr_d = ptr_after(idx_q);
          timer_d  = 20'd0;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (timer_q == IFG_LAST) begin
          timer_d = 20'd0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 20'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= 3'd0;
      idx_q    <= 3'd0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      tmo_q    <= 1'b0;
      len_q    <= 16'd0;
      timer_q  <= 20'd0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      len_q    <= len_d;
      timer_q  <= timer_d;
    end
  end

  assign gnt               = gnt_q;
  assign req_done          = done_q;
  assign req_err           = err_q;
  assign timeout_err       = tmo_q;
  assign udp_tx_length     = len_q;
  assign busy              = (state_q != S_IDLE);
  assign udp_tx_start      = (state_q == S_START);
  assign udp_tx_data       = (|gnt_q) ? dat_arr[idx_q] : 8'd0;
  assign udp_tx_data_valid = (|gnt_q) ? vld_pad[idx_q] : 1'b0;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb/tb_udp_tx_arbiter.sv - randomized self-checking bench for udp_tx_arbiter against a frame-level model
module tb_udp_tx_arbiter;
  localparam int N   = 4;
  localparam int IFG = 12;
  localparam int TMO = 100;

  logic             rgmii_clk = 1'b0;
  logic             rstn;
  logic [N-1:0]     req;
  logic [16*N-1:0]  req_len;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_data_valid;
  logic [N-1:0]     gnt, req_done, req_err;
  logic             udp_tx_ready, udp_tx_start;
  logic [15:0]      udp_tx_length;
  logic [7:0]       udp_tx_data;
  logic             udp_tx_data_valid, udp_tx_done, busy, timeout_err;

  always #4 rgmii_clk = ~rgmii_clk;

  udp_tx_arbiter #(
    .N_REQ(N), .MAX_LEN(16'd1472), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(20'(TMO))
  ) dut (
    .rgmii_clk(rgmii_clk), .rstn(rstn), .req(req), .req_len(req_len),
    .req_data(req_data), .req_data_valid(req_data_valid), .gnt(gnt),
    .req_done(req_done), .req_err(req_err), .udp_tx_ready(udp_tx_ready),
    .udp_tx_start(udp_tx_start), .udp_tx_length(udp_tx_length),
    .udp_tx_data(udp_tx_data), .udp_tx_data_valid(udp_tx_data_valid),
    .udp_tx_done(udp_tx_done), .busy(busy), .timeout_err(timeout_err)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          model_ptr;
  int          exp_evt;
  bit [N-1:0]  mreq;
  logic [15:0] mlen [N];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge rgmii_clk);
    cyc++;
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req[i]              = mreq[i];
      req_len[16*i +: 16] = mlen[i];
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (mreq[(model_ptr + k) % N]) return (model_ptr + k) % N;
    return -1;
  endfunction

  function automatic bit legal(input int w);
    return mlen[w] != 16'd0 && mlen[w] <= 16'd1472;
  endfunction

  function automatic logic [15:0] rand_len();
    case ($urandom_range(0, 5))
      0:       return 16'd0;
      1:       return 16'(1473 + $urandom_range(0, 100));
      2:       return 16'd1472;
      3:       return 16'd1;
      default: return 16'($urandom_range(1, 1472));
    endcase
  endfunction

  // delay: cycles from the start cycle to the done pulse; 0 means the engine never answers.
  task automatic serve(input int delay, input bit keep, output int won);
    int w, waited, s, last;
    logic [7:0] exp_byte;
    w   = pick();
    won = w;
    if (w < 0) begin
      check_eq("model_pick", 0, 1);
      return;
    end
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!(udp_tx_start || (|req_err)) && waited < 300);
    if (!(udp_tx_start || (|req_err))) begin
      check_eq("event_wait", 0, 1);
      mreq = '0;
      drive_req();
      return;
    end
    check_eq("evt_cycle", cyc, exp_evt);
    if (!legal(w)) begin
      check_eq("req_err", req_err, 32'(1 << w));
      check_eq("no_start", udp_tx_start, 0);
      check_eq("err_no_gnt", gnt, 0);
      mreq[w]   = 1'b0;
      drive_req();
      model_ptr = (w + 1) % N;
      exp_evt   = cyc + 2;
      return;
    end
    check_eq("start", udp_tx_start, 1);
    check_eq("gnt", gnt, 32'(1 << w));
    check_eq("length", udp_tx_length, mlen[w]);
    check_eq("busy_start", busy, 1);
    s    = cyc;
    last = (delay > 0) ? delay : TMO - 1;
    for (int k = 1; k <= last; k++) begin
      tick();
      req_data       = $urandom;
      req_data_valid = N'($urandom);
      #1;
      exp_byte = req_data[8*w +: 8];
      check_eq("data_mux", udp_tx_data, exp_byte);
      check_eq("valid_mux", udp_tx_data_valid, req_data_valid[w]);
      check_eq("gnt_hold", gnt, 32'(1 << w));
      check_eq("no_early_done", req_done, 0);
      check_eq("no_start_busy", udp_tx_start, 0);
      if (delay > 0 && k == delay) udp_tx_done = 1'b1;
    end
    tick();
    udp_tx_done = 1'b0;
    check_eq("req_done", req_done, 32'(1 << w));
    check_eq("gnt_clear", gnt, 0);
    check_eq("timeout_err", timeout_err, (delay > 0) ? 0 : 1);
    if (!keep) begin
      mreq[w] = 1'b0;
      drive_req();
    end
    model_ptr = (w + 1) % N;
    repeat (IFG - 1) tick();
    check_eq("busy_gap", busy, 1);
    tick();
    check_eq("idle_after_gap", busy, 0);
    check_eq("idle_data_zero", udp_tx_data, 0);
    exp_evt = s + last + IFG + 3;
  endtask

  int w_got, bad, waited;
  int order [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    rstn = 1'b0;
    req = '0; req_len = '0; req_data = '0; req_data_valid = '0;
    udp_tx_ready = 1'b1; udp_tx_done = 1'b0;
    mreq = '0;
    for (int i = 0; i < N; i++) mlen[i] = 16'd0;
    model_ptr = 0;
    repeat (3) tick();
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_start", udp_tx_start, 0);
    check_eq("rst_len", udp_tx_length, 0);
    check_eq("rst_pulses", {req_done, req_err, 7'd0, timeout_err}, 0);
    rstn = 1'b1;
    tick();

    // Engine not ready: request must wait.
    udp_tx_ready = 1'b0;
    mreq = 4'b0001; mlen[0] = 16'd64; drive_req();
    bad = 0;
    repeat (50) begin
      tick();
      if (udp_tx_start || busy) bad++;
    end
    check_eq("ready_low_idle", bad, 0);
    udp_tx_ready = 1'b1;
    exp_evt = cyc + 2;
    serve(20, 1'b0, w_got);

    // Illegal lengths, then pointer must sit at 3.
    mreq = 4'b0100; mlen[2] = 16'd0; drive_req(); exp_evt = cyc + 2;
    serve(10, 1'b0, w_got);
    mreq = 4'b0100; mlen[2] = 16'd1473; drive_req(); exp_evt = cyc + 2;
    serve(10, 1'b0, w_got);
    mreq = 4'b1111;
    for (int i = 0; i < N; i++) mlen[i] = 16'd32;
    drive_req(); exp_evt = cyc + 2;
    serve(10, 1'b0, w_got);
    check_eq("rr_after_err", w_got, 3);
    while (mreq != 0) serve(5, 1'b0, w_got);

    // Timeout with a never-answering engine.
    mreq = 4'b0001; mlen[0] = 16'd200; drive_req(); exp_evt = cyc + 2;
    serve(0, 1'b0, w_got);

    // Reset while a frame is in flight.
    mreq = 4'b0100; mlen[2] = 16'd100; drive_req();
    waited = 0;
    while (!udp_tx_start && waited < 20) begin
      tick();
      waited++;
    end
    check_eq("pre_reset_start", udp_tx_start, 1);
    repeat (5) tick();
    rstn = 1'b0;
    #1;
    check_eq("rst_mid_gnt", gnt, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_len", udp_tx_length, 0);
    mreq = '0; drive_req();
    tick();
    rstn = 1'b1;
    model_ptr = 0;

    // Fairness with 1011 held: order 0,1,3,0,1,3 and 55-cycle start spacing.
    mreq = 4'b1011;
    for (int i = 0; i < N; i++) mlen[i] = 16'd32;
    drive_req(); exp_evt = cyc + 2;
    for (int i = 0; i < 6; i++) begin
      serve(40, 1'b1, w_got);
      check_eq("rr_order", w_got, order[i]);
    end
    while (mreq != 0) serve(8, 1'b0, w_got);

    // Randomized episodes.
    for (int ep = 0; ep < 15; ep++) begin
      int frames, r, d;
      bit kp;
      mreq = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) mlen[i] = rand_len();
      drive_req();
      exp_evt = cyc + 2;
      frames = 0;
      while (mreq != 0) begin
        r = $urandom_range(0, 9);
        d = (r < 7) ? $urandom_range(1, 60) : (r == 7) ? TMO - 1 : 0;
        kp = (frames < 6) && ($urandom_range(0, 3) == 0);
        serve(d, kp, w_got);
        frames++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
